// File: rtl/program_loader.sv
// Boot-time image loader: takes a framed byte stream, assembles big-endian words,
// writes them to instruction memory and releases the core once the checksum matches.
module program_loader #(
  parameter int IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        core_resetN,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, CHECK, DONE, ERR} state_t;

  localparam logic [15:0] MAX_N = 16'(IMEM_WORDS);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic [7:0]  csum;
  logic        accept;

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= CNT_HI;
      cnt          <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      shreg        <= '0;
      csum         <= '0;
      rx_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      core_resetN  <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      imem_wr_en <= 1'b0;
      case (state)
        CNT_HI: begin
          // rx_ready comes up one cycle after reset release
          rx_ready <= 1'b1;
          if (accept) begin
            cnt   <= {rx_data, 8'd0};
            state <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            cnt      <= {cnt[15:8], rx_data};
            word_idx <= '0;
            byte_idx <= '0;
            if ({cnt[15:8], rx_data} > MAX_N) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              load_err <= 1'b1;
            end else if ({cnt[15:8], rx_data} == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shreg    <= {shreg[15:0], rx_data};
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            // Last byte of a word: strobe the completed word next cycle
            if (byte_idx == 2'd3) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= {14'd0, word_idx, 2'b00};
              imem_wr_data <= {shreg, rx_data};
              word_idx     <= word_idx + 16'd1;
              if (word_idx == cnt - 16'd1) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state       <= DONE;
              core_resetN <= 1'b1;
              load_done   <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (reload) begin
            state       <= CNT_HI;
            cnt         <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            csum        <= '0;
            rx_ready    <= 1'b1;
            core_resetN <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
          end
        end
        default: begin
          state    <= ERR;
          rx_ready <= 1'b0;
          load_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time instruction loader upstream of the single-cycle MIPS core.
- Receives a framed program image over a byte-wide valid/ready stream and assembles big-endian 32-bit words.
- Writes each word into instruction memory through a write port.
- Holds the core in reset until the whole image is loaded and its checksum matches.

Parameters:
IMEM_WORDS, 64, instruction-memory capacity in 32-bit words; upper bound on the accepted word count (1..65535)

Ports:
clk  input  1  system clock; all state changes on its rising edge
resetN  input  1  asynchronous active-low reset
rx_data  input  8  incoming image byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader can accept a byte this cycle
reload  input  1  synchronous request to restart loading; honoured only in DONE or ERR
imem_wr_en  output  1  one-cycle instruction-memory write strobe
imem_wr_addr  output  32  byte address of the word being written; always word-aligned
imem_wr_data  output  32  word being written
core_resetN  output  1  active-low reset to the MIPS core; high only in DONE
load_done  output  1  high while in DONE
load_err  output  1  high while in ERR

Behaviour:
- Reset: clk and resetN as named above; reset is asynchronous, active-low. While resetN is low:
  - state=CNT_HI, rx_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, core_resetN=0, load_done=0, load_err=0.
  - All counters, the byte shift register and the checksum clear to 0.
  - Reset asserted mid-load aborts the load at once; partially written memory is not cleared.
- Byte transfer: a byte is accepted on a rising edge where rx_valid=1 and rx_ready=1. The upstream side may hold rx_valid high across cycles.
- rx_ready is 1 in states CNT_HI, CNT_LO, DATA and CHECK, and 0 in DONE and ERR. It has no combinational dependence on rx_valid.
- Frame format:
  - Word count N: 16 bits, big-endian (high byte first).
  - Payload: 4*N bytes, each word sent MSB byte first.
  - Checksum: 1 byte, equal to the XOR of all 4*N payload bytes. Count bytes are excluded.
- State machine:
  - CNT_HI: accept byte -> store as N[15:8] -> CNT_LO.
  - CNT_LO: accept byte -> N[7:0].
    - If N > IMEM_WORDS -> ERR.
    - Else if N == 0 -> CHECK.
    - Else -> DATA, with word index=0 and byte index=0.
  - DATA: each accepted byte shifts into a 32-bit register (word = {word[23:0], rx_data}) and XORs into the checksum.
    - On the 4th byte of a word, the next cycle drives imem_wr_en=1 for exactly one cycle, with imem_wr_addr=index*4 and imem_wr_data=the assembled word.
    - The word index then increments.
    - After word N-1 is accepted -> CHECK.
    - Back-to-back bytes at full rate are supported; a write strobe may coincide with acceptance of the next word's first byte.
  - CHECK: accept byte. Equal to the running checksum -> DONE; otherwise -> ERR.
  - DONE: core_resetN=1 and load_done=1, both registered, so they become 1 on the cycle after the checksum byte is accepted.
  - ERR: core_resetN=0 and load_err=1.
  - DONE or ERR with reload=1 -> CNT_HI. Checksum, counters and flags clear. core_resetN falls on the next edge.
  - reload is ignored in every other state.
- imem_wr_addr and imem_wr_data hold their last values between strobes.
- Max N=65535: the word index is 16 bits, and the byte address is index*4, zero-extended to 32 bits.

Test Plan:
- Nominal load: bytes 00 02 | 20 08 00 05 | 00 00 00 08 | checksum 0x25.
  - -> Write strobes at addr 0x0 with data 0x20080005, and at addr 0x4 with data 0x00000008.
  - -> load_done=1 and core_resetN=1 one cycle after the checksum byte; rx_ready=0 afterwards.
- Bad checksum: same frame with checksum 0x24 -> both words still written; load_err=1; core_resetN stays 0.
- Oversize count, IMEM_WORDS=64: bytes 00 41 -> ERR on the cycle after the 2nd byte; no write strobes.
- Zero count: bytes 00 00 00 -> DONE with no writes. A checksum byte of 0x01 instead -> ERR.
- Throttled stream: rx_valid toggled randomly over the nominal frame -> identical writes; no duplicated or dropped bytes.
- Reload and mid-load reset:
  - reload=1 in DONE -> core_resetN=0 next cycle; a new frame then loads correctly.
  - resetN pulsed low after 5 payload bytes -> all outputs return to reset values immediately.
